cpu_trace_buffer: RTL and testbench
===================================

Name: cpu_trace_buffer

Overview:
Synthesizable on-chip execution trace capture unit for the pipelined MIPS CPU. It records one entry per retiring sample into a circular buffer of parametrised depth. Each entry holds PC, instruction, write-back select and write-back data. A PC-match trigger freezes the buffer after a programmable number of post-trigger samples; the frozen contents are then read out oldest-first through an indexed port.

Parameters:
ADDR_W, 32, PC width
DATA_W, 32, instruction and write-back data width
DEPTH, 16, number of trace entries; power of two, ≥4
IDX_W, 4, log2(DEPTH)
POST_TRIG, 8, samples captured after the trigger entry; legal range 0..DEPTH-1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
arm  in  1  single-cycle pulse; clears the buffer and starts capture
sample_valid  in  1  current pipeline sample is valid (low during stall/bubble)
pc  in  ADDR_W  PC of sample
instr  in  DATA_W  instruction of sample
wb_sel  in  2  write-back select of sample
wb_data  in  DATA_W  write-back data of sample
trig_en  in  1  enable PC-match trigger
trig_pc  in  ADDR_W  trigger PC value
rd_idx  in  IDX_W  readout index; 0 = oldest stored entry
rd_en  in  1  readout request
rd_valid  out  1  readout data valid, one cycle after rd_en
rd_pc  out  ADDR_W  readout PC
rd_instr  out  DATA_W  readout instruction
rd_wb_sel  out  2  readout write-back select
rd_wb_data  out  DATA_W  readout write-back data
count  out  IDX_W+1  stored entries, saturates at DEPTH
state  out  2  00 IDLE, 01 PRE, 10 POST, 11 DONE
triggered  out  1  high from trigger capture until next arm/rst

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, wr_ptr=0, count=0, post counter=0, triggered=0, rd_valid=0, all rd_* data=0. Memory contents need not be cleared. Reset overrides every other input, including mid-capture.
- IDLE: no capture. arm -> PRE with wr_ptr=0, count=0, triggered=0.
- PRE: each cycle with sample_valid=1 writes {pc,instr,wb_sel,wb_data} at wr_ptr. wr_ptr increments mod DEPTH; count increments, saturating at DEPTH. Overwrites the oldest entry when full.
- Trigger: the condition is PC match in PRE, i.e. sample_valid & trig_en & pc==trig_pc. The matching sample is captured.
  - POST_TRIG=0: next state DONE.
  - Otherwise: next state POST with post counter=POST_TRIG.
  - Both cases: triggered=1.
- POST: each valid sample is captured and decrements the counter. The capture that brings the counter to 0 moves to DONE. Further PC matches in POST are ignored.
- DONE: no writes, contents frozen. arm -> PRE, clearing count/wr_ptr/triggered.
- arm in PRE or POST restarts capture identically. arm wins over a same-cycle trigger, and that cycle's sample is not captured.
- sample_valid=0 in PRE/POST: no write, no pointer/count/counter change.
- Readout: physical address = (wr_ptr - count + rd_idx) mod DEPTH.
  - rd_en registers the address; rd_valid=1 and rd_* data appear on the next cycle. rd_valid is low otherwise.
  - rd_idx ≥ count: rd_valid=1 with rd_* all zero.
  - Reads are legal in any state. A read in PRE/POST returns the value before any same-cycle write (read-before-write).
- Latency: capture at the edge where sample_valid=1; count visible the following cycle.

Test Plan:
- Reset mid-POST: arm, 5 valid samples, trigger, rst=1 -> next cycle state=00, count=0, triggered=0, rd_valid=0.
- Underfill: DEPTH=16, POST_TRIG=2, arm, samples pc=0x00,0x04,0x08,0x0C; trig_pc=0x08 -> after 0x0C and 0x10 captured, state=11, count=5; rd_idx=0 gives pc=0x00, rd_idx=4 gives pc=0x10, rd_idx=5 gives rd_valid=1 with zero data.
- Wrap: 40 valid samples pc=4*i, trigger on pc=0x90 (i=36), POST_TRIG=3 -> count=16, rd_idx=0 gives pc=0x60 (i=24), rd_idx=15 gives pc=0x9C.
- Stalls: alternate sample_valid 1/0 for 10 cycles in PRE -> count=5, no duplicate entries; a matching PC with sample_valid=0 does not trigger.
- POST_TRIG=0 with trig_pc=0x20 -> state=11 on the cycle after 0x20 is captured; rd_idx=count-1 gives pc=0x20 with that sample's wb_sel/wb_data.
- Re-arm from DONE: arm, then 3 samples -> count=3, triggered=0, old entries not readable (rd_idx=3 gives zeros).

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// Execution trace capture: circular buffer of retiring samples with a PC-match
// trigger that freezes the buffer after a programmable number of post-trigger samples.
module cpu_trace_buffer #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned POST_TRIG = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              sample_valid,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] instr,
    input  logic [1:0]        wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              trig_en,
    input  logic [ADDR_W-1:0] trig_pc,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_pc,
    output logic [DATA_W-1:0] rd_instr,
    output logic [1:0]        rd_wb_sel,
    output logic [DATA_W-1:0] rd_wb_data,
    output logic [IDX_W:0]    count,
    output logic [1:0]        state,
    output logic              triggered
);

    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PRE  = 2'b01,
        S_POST = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_wr_ptr;
    logic [IDX_W-1:0]   w_wr_ptr_nxt;
    logic [IDX_W-1:0]   r_post_cnt;
    logic [IDX_W-1:0]   w_post_cnt_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               r_triggered;
    logic               w_triggered_nxt;
    logic               w_wr_en;
    logic               w_match;
    logic [IDX_W-1:0]   w_rd_addr;
    logic               w_rd_hit;

    logic [ADDR_W-1:0]  r_mem_pc    [DEPTH];
    logic [DATA_W-1:0]  r_mem_instr [DEPTH];
    logic [1:0]         r_mem_sel   [DEPTH];
    logic [DATA_W-1:0]  r_mem_data  [DEPTH];

    logic               r_rd_valid;
    logic [ADDR_W-1:0]  r_rd_pc;
    logic [DATA_W-1:0]  r_rd_instr;
    logic [1:0]         r_rd_sel;
    logic [DATA_W-1:0]  r_rd_data;

    assign w_match = sample_valid & trig_en & (pc == trig_pc);

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_post_cnt  <= '0;
            r_count     <= '0;
            r_triggered <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_post_cnt  <= w_post_cnt_nxt;
            r_count     <= w_count_nxt;
            r_triggered <= w_triggered_nxt;
        end
    end

    // Next-state and capture control; arm restarts from any state and suppresses capture
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_post_cnt_nxt  = r_post_cnt;
        w_count_nxt     = r_count;
        w_triggered_nxt = r_triggered;
        w_wr_en         = 1'b0;

        if (arm) begin
            w_state_nxt     = S_PRE;
            w_wr_ptr_nxt    = '0;
            w_post_cnt_nxt  = '0;
            w_count_nxt     = '0;
            w_triggered_nxt = 1'b0;
        end else begin
            case (r_state)
                S_PRE: begin
                    if (sample_valid) begin
                        w_wr_en      = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + IDX_W'(1);
                        if (r_count != CNT_W'(DEPTH)) begin
                            w_count_nxt = r_count + CNT_W'(1);
                        end
                        if (w_match) begin
                            w_triggered_nxt = 1'b1;
                            if (POST_TRIG == 0) begin
                                w_state_nxt = S_DONE;
                            end else begin
                                w_state_nxt    = S_POST;
                                w_post_cnt_nxt = IDX_W'(POST_TRIG);
                            end
                        end
                    end
                end
                S_POST: begin
                    if (sample_valid) begin
                        w_wr_en        = 1'b1;
                        w_wr_ptr_nxt   = r_wr_ptr + IDX_W'(1);
                        w_post_cnt_nxt = r_post_cnt - IDX_W'(1);
                        if (r_count != CNT_W'(DEPTH)) begin
                            w_count_nxt = r_count + CNT_W'(1);
                        end
                        if (r_post_cnt == IDX_W'(1)) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_IDLE, S_DONE: begin
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Trace storage; not cleared by reset
    always_ff @(posedge clk) begin
        if (w_wr_en && !rst) begin
            r_mem_pc[r_wr_ptr]    <= pc;
            r_mem_instr[r_wr_ptr] <= instr;
            r_mem_sel[r_wr_ptr]   <= wb_sel;
            r_mem_data[r_wr_ptr]  <= wb_data;
        end
    end

    // Index 0 maps to the oldest stored entry
    assign w_rd_addr = r_wr_ptr - r_count[IDX_W-1:0] + rd_idx;
    assign w_rd_hit  = ({1'b0, rd_idx} < r_count);

    // Registered readout; memory sampled before any same-edge write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_pc    <= '0;
            r_rd_instr <= '0;
            r_rd_sel   <= '0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                if (w_rd_hit) begin
                    r_rd_pc    <= r_mem_pc[w_rd_addr];
                    r_rd_instr <= r_mem_instr[w_rd_addr];
                    r_rd_sel   <= r_mem_sel[w_rd_addr];
                    r_rd_data  <= r_mem_data[w_rd_addr];
                end else begin
                    r_rd_pc    <= '0;
                    r_rd_instr <= '0;
                    r_rd_sel   <= '0;
                    r_rd_data  <= '0;
                end
            end
        end
    end

    assign rd_valid   = r_rd_valid;
    assign rd_pc      = r_rd_pc;
    assign rd_instr   = r_rd_instr;
    assign rd_wb_sel  = r_rd_sel;
    assign rd_wb_data = r_rd_data;
    assign count      = r_count;
    assign state      = r_state;
    assign triggered  = r_triggered;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: three instances (POST_TRIG 2, 3, 0) share
// stimulus; readouts are checked from a vector table, control via hand sequences.
module tb_cpu_trace_buffer;

    logic        clk = 1'b0;
    logic        rst, arm, sample_valid, trig_en, rd_en;
    logic [31:0] pc, instr, wb_data, trig_pc;
    logic [1:0]  wb_sel;
    logic [3:0]  rd_idx;

    logic        o_rd_valid [3];
    logic [31:0] o_rd_pc    [3];
    logic [31:0] o_rd_instr [3];
    logic [1:0]  o_rd_sel   [3];
    logic [31:0] o_rd_data  [3];
    logic [4:0]  o_count    [3];
    logic [1:0]  o_state    [3];
    logic        o_trig     [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned PT = (g == 0) ? 2 : ((g == 1) ? 3 : 0);
        cpu_trace_buffer #(.POST_TRIG(PT)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .arm          (arm),
            .sample_valid (sample_valid),
            .pc           (pc),
            .instr        (instr),
            .wb_sel       (wb_sel),
            .wb_data      (wb_data),
            .trig_en      (trig_en),
            .trig_pc      (trig_pc),
            .rd_idx       (rd_idx),
            .rd_en        (rd_en),
            .rd_valid     (o_rd_valid[g]),
            .rd_pc        (o_rd_pc[g]),
            .rd_instr     (o_rd_instr[g]),
            .rd_wb_sel    (o_rd_sel[g]),
            .rd_wb_data   (o_rd_data[g]),
            .count        (o_count[g]),
            .state        (o_state[g]),
            .triggered    (o_trig[g])
        );
    end

    typedef struct {
        int          scen;
        int          dut;
        logic [3:0]  idx;
        logic        hit;
        logic [31:0] pc;
    } rd_vec_t;

    rd_vec_t rv[$];

    function automatic logic [31:0] f_instr(input logic [31:0] p);
        return 32'h2400_0000 | {16'h0, p[15:0]};
    endfunction
    function automatic logic [1:0] f_sel(input logic [31:0] p);
        return p[3:2];
    endfunction
    function automatic logic [31:0] f_data(input logic [31:0] p);
        return p + 32'h0001_0000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sample(input logic [31:0] p);
        pc      = p;
        instr   = f_instr(p);
        wb_sel  = f_sel(p);
        wb_data = f_data(p);
    endtask

    task automatic samp(input logic [31:0] p);
        set_sample(p);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic chk_ctl(input string nm, input int d, input logic [1:0] st,
                           input logic [4:0] cnt, input logic tr);
        chk({nm, " state"}, 64'(o_state[d]), 64'(st));
        chk({nm, " count"}, 64'(o_count[d]), 64'(cnt));
        chk({nm, " triggered"}, 64'(o_trig[d]), 64'(tr));
    endtask

    task automatic rd_check(input int d, input logic [3:0] idx, input logic hit,
                            input logic [31:0] p, input string nm);
        rd_idx = idx;
        rd_en  = 1'b1;
        tick();
        rd_en  = 1'b0;
        chk({nm, " rd_valid"}, 64'(o_rd_valid[d]), 64'(1'b1));
        chk({nm, " rd_pc"}, 64'(o_rd_pc[d]), 64'(hit ? p : 32'h0));
        chk({nm, " rd_instr"}, 64'(o_rd_instr[d]), 64'(hit ? f_instr(p) : 32'h0));
        chk({nm, " rd_wb_sel"}, 64'(o_rd_sel[d]), 64'(hit ? f_sel(p) : 2'b00));
        chk({nm, " rd_wb_data"}, 64'(o_rd_data[d]), 64'(hit ? f_data(p) : 32'h0));
    endtask

    task automatic run_reads(input int s);
        foreach (rv[i]) begin
            if (rv[i].scen == s) begin
                rd_check(rv[i].dut, rv[i].idx, rv[i].hit, rv[i].pc,
                         $sformatf("s%0d dut%0d idx%0d", s, rv[i].dut, rv[i].idx));
            end
        end
    endtask

    initial begin
        // Readout vectors: {scenario, instance, rd_idx, entry present, expected pc}
        rv.push_back('{2, 0, 4'd0,  1'b1, 32'h00});
        rv.push_back('{2, 0, 4'd2,  1'b1, 32'h08});
        rv.push_back('{2, 0, 4'd4,  1'b1, 32'h10});
        rv.push_back('{2, 0, 4'd5,  1'b0, 32'h00});
        rv.push_back('{3, 1, 4'd0,  1'b1, 32'h60});
        rv.push_back('{3, 1, 4'd8,  1'b1, 32'h80});
        rv.push_back('{3, 1, 4'd15, 1'b1, 32'h9C});
        rv.push_back('{4, 1, 4'd1,  1'b1, 32'h204});
        rv.push_back('{4, 1, 4'd4,  1'b1, 32'h210});
        rv.push_back('{4, 1, 4'd5,  1'b0, 32'h0});
        rv.push_back('{5, 2, 4'd0,  1'b1, 32'h18});
        rv.push_back('{5, 2, 4'd2,  1'b1, 32'h20});
        rv.push_back('{6, 2, 4'd0,  1'b1, 32'h500});
        rv.push_back('{6, 2, 4'd2,  1'b1, 32'h508});
        rv.push_back('{6, 2, 4'd3,  1'b0, 32'h0});
        rv.push_back('{7, 1, 4'd0,  1'b1, 32'h604});

        rst = 1'b1; arm = 1'b0; sample_valid = 1'b0; trig_en = 1'b0; rd_en = 1'b0;
        trig_pc = 32'h0; rd_idx = 4'd0;
        set_sample(32'h0);
        tick();
        tick();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk_ctl($sformatf("reset dut%0d", d), d, 2'b00, 5'd0, 1'b0);
            chk($sformatf("reset dut%0d rd_valid", d), 64'(o_rd_valid[d]), 64'(1'b0));
            chk($sformatf("reset dut%0d rd_pc", d), 64'(o_rd_pc[d]), 64'(32'h0));
        end

        // 1: reset while in POST
        trig_en = 1'b1; trig_pc = 32'h114;
        do_arm();
        chk_ctl("s1 armed", 1, 2'b01, 5'd0, 1'b0);
        for (int i = 0; i < 5; i++) samp(32'h100 + 32'(4 * i));
        samp(32'h114);
        chk_ctl("s1 post", 1, 2'b10, 5'd6, 1'b1);
        chk_ctl("s1 pt0 done", 2, 2'b11, 5'd6, 1'b1);
        rst = 1'b1; rd_en = 1'b1; rd_idx = 4'd0;
        tick();
        rst = 1'b0; rd_en = 1'b0;
        chk_ctl("s1 after rst", 1, 2'b00, 5'd0, 1'b0);
        chk("s1 after rst rd_valid", 64'(o_rd_valid[1]), 64'(1'b0));

        // 2: underfill, POST_TRIG=2
        trig_pc = 32'h08;
        do_arm();
        samp(32'h00); samp(32'h04); samp(32'h08);
        chk_ctl("s2 trig", 0, 2'b10, 5'd3, 1'b1);
        samp(32'h0C);
        chk_ctl("s2 post1", 0, 2'b10, 5'd4, 1'b1);
        samp(32'h10);
        chk_ctl("s2 done", 0, 2'b11, 5'd5, 1'b1);
        samp(32'h14);
        chk_ctl("s2 frozen", 0, 2'b11, 5'd5, 1'b1);
        run_reads(2);
        tick();
        chk("s2 rd_valid drops", 64'(o_rd_valid[0]), 64'(1'b0));

        // 3: wrap, POST_TRIG=3
        trig_pc = 32'h90;
        do_arm();
        for (int i = 0; i < 40; i++) samp(32'(4 * i));
        chk_ctl("s3 done", 1, 2'b11, 5'd16, 1'b1);
        run_reads(3);

        // 4: stalls with a matching PC on invalid cycles
        trig_pc = 32'h300;
        do_arm();
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) begin
                set_sample(32'h200 + 32'(4 * (k / 2)));
                sample_valid = 1'b1;
            end else begin
                set_sample(32'h300);
                sample_valid = 1'b0;
            end
            tick();
        end
        sample_valid = 1'b0;
        chk_ctl("s4 stalls", 1, 2'b01, 5'd5, 1'b0);
        run_reads(4);

        // 5: POST_TRIG=0 freezes right after the trigger sample
        trig_pc = 32'h20;
        do_arm();
        samp(32'h18); samp(32'h1C);
        chk_ctl("s5 pre", 2, 2'b01, 5'd2, 1'b0);
        samp(32'h20);
        chk_ctl("s5 done", 2, 2'b11, 5'd3, 1'b1);
        samp(32'h24);
        chk_ctl("s5 frozen", 2, 2'b11, 5'd3, 1'b1);
        run_reads(5);

        // 6: re-arm from DONE
        trig_en = 1'b0;
        do_arm();
        chk_ctl("s6 rearm", 2, 2'b01, 5'd0, 1'b0);
        samp(32'h500); samp(32'h504); samp(32'h508);
        chk_ctl("s6 filled", 2, 2'b01, 5'd3, 1'b0);
        run_reads(6);

        // 7: arm beats a same-cycle trigger and drops that sample
        trig_en = 1'b1; trig_pc = 32'h600;
        set_sample(32'h600);
        arm = 1'b1; sample_valid = 1'b1;
        tick();
        arm = 1'b0; sample_valid = 1'b0;
        chk_ctl("s7 arm wins", 1, 2'b01, 5'd0, 1'b0);
        samp(32'h604);
        chk_ctl("s7 one entry", 1, 2'b01, 5'd1, 1'b0);
        run_reads(7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
